alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the 4:1 ALU result multiplexer.
- Captures the selected result word, the 2-bit select tag, and the carry/overflow side-band.
- Computes N/Z flags and presents result plus NZCV flags to the consumer over a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with no combinational path from out_ready to in_ready.

Parameters:
- WIDTH, 4: result data width in bits; must be ≥ 2.
- TAG_W, 2: width of the operation tag, equal to the mux select width.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  stage can accept a result.
- in_data  in  WIDTH  mux output Y.
- in_tag  in  TAG_W  mux select value that produced in_data.
- in_carry  in  1  carry-out of the selected operation.
- in_ovf  in  1  signed overflow of the selected operation.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  WIDTH  head result.
- out_tag  out  TAG_W  head tag.
- out_flags  out  4  {N,Z,C,V} of head.

Behaviour:
- Reset, asynchronous, any cycle including mid-transfer:
  - state=EMPTY; both entries cleared to 0.
  - out_valid=0, out_data=0, out_tag=0, out_flags=4'b0100 (Z=1 for the zero head).
  - in_ready=1.
  - Entries in flight are discarded.
- push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated at the rising edge.
- States, each with (in_ready, out_valid):
  - EMPTY: (1, 0).
  - ONE: (1, 1).
  - TWO: (0, 1).
- in_ready and out_valid are decoded from the state register only; no combinational input-to-output path.
- Transitions:
  - EMPTY: push → ONE, head ← input.
  - ONE, push & pop: stay ONE, head ← input.
  - ONE, push only: → TWO, tail ← input.
  - ONE, pop only: → EMPTY.
  - TWO, pop: → ONE, head ← tail.
  - TWO, no pop: hold. in_valid is ignored because in_ready=0.
- Latency: a result pushed at edge k is visible on out_* in cycle k+1 when the buffer was empty.
- Throughput: 1 result/cycle sustained when out_ready is held high.
- Flags are computed at push and stored with the entry:
  - N = in_data[WIDTH-1].
  - Z = (in_data == 0).
  - C = in_carry.
  - V = in_ovf.
- Hold rule: out_* stay stable while out_valid=1 and out_ready=0.
- Flag and tag side-band fields are never reordered relative to their data.
- X on in_data is tolerated while in_valid=0; it is never captured.

Optional Feature:
- ALU_RESULT_CNT_EN defined:
  - Adds output port result_count, 8 bits, reset 0.
  - Increments by 1 on every pop and wraps 255 → 0.
  - A pop in the same cycle as reset release is not counted.
- Not defined: the port and its counter logic are absent. All other behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - enum buf_state_t {EMPTY, ONE, TWO}.
  - packed struct alu_entry_t {data, tag, flags}.
- Sub-module alu_flag_gen, combinational, derives NZCV from data, carry and overflow.
- The buffer control stays in alu_result_stage.

Test Plan:
- Reset check: rst=1 asynchronously mid-cycle → out_valid=0, out_flags=4'b0100 and in_ready=1 immediately, before any clk edge.
- Single transfer: in_data=4'b1000, in_tag=2'b11, carry=1, ovf=0, out_ready=1 → next cycle out_data=4'b1000, out_tag=2'b11, out_flags=4'b1010.
- Back-pressure: push 4'b0001 then 4'b0010 with out_ready=0 → state TWO and in_ready=0. A third in_valid of 4'b0100 is not accepted. Raising out_ready drains 0001, then 0010, in order.
- Streaming: push the four values 0001, 0010, 0100, 1000 with tags 00–11 on consecutive cycles, out_ready=1 → identical sequence appears one cycle later with no bubbles. Flags: Z=0 on all; N=1 only for 1000.
- Zero result: in_data=4'b0000, ovf=1 → out_flags=4'b0101.
- With ALU_RESULT_CNT_EN: 257 pops → result_count=1. Assert rst while count is 5 → result_count=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result output stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the NZCV bit positions, the skid-buffer state encoding and the
// packed entry type (result word + tag + flags) stored in each buffer slot.
package alu_pkg;

  // Widths of the entry fields; alu_result_stage parameters default to these
  // and must match them, since the entry type is shared through this package.
  localparam int ALU_WIDTH = 4;
  localparam int ALU_TAG_W = 2;

  // Bit positions inside the 4-bit {N,Z,C,V} flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Flags of an all-zero result with no carry/overflow: only Z is set.
  localparam logic [3:0] ZERO_FLAGS = 4'b0100;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] data;
    logic [ALU_TAG_W-1:0] tag;
    logic [3:0]           flags;
  } alu_entry_t;

  // Cleared entry: zero data and tag, flags self-consistent with zero data.
  localparam alu_entry_t ZERO_ENTRY = '{data: '0, tag: '0, flags: ZERO_FLAGS};

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational NZCV flag derivation for one ALU result word.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the flags are captured.
//
// Ports: data (result word), carry (carry-out), ovf (signed overflow),
//        flags ({N,Z,C,V}, bit positions from alu_pkg).
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  input  logic             carry,
  input  logic             ovf,
  output logic [3:0]       flags
);

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = data[WIDTH-1];
    flags[FLAG_Z] = (data == '0);
    flags[FLAG_C] = carry;
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage after the ALU result mux: captures result, tag and NZCV.
// Latency: 1 cycle from push into an empty buffer to out_valid; 1 result/cycle sustained.
// Backpressure: 2-entry skid buffer; in_ready is a pure state decode (no out_ready path).
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   in_valid/in_ready        upstream handshake; in_data, in_tag, in_carry, in_ovf payload
//   out_valid/out_ready      downstream handshake; out_data, out_tag, out_flags ({N,Z,C,V})
//   result_count             8-bit wrapping pop counter, present only when the
//                            ALU_RESULT_CNT_EN macro is defined
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,  // >= 2, must equal ALU_WIDTH
  parameter int TAG_W = ALU_TAG_W   // must equal ALU_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_carry,
  input  logic             in_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags
`ifdef ALU_RESULT_CNT_EN
  ,
  output logic [7:0]       result_count
`endif
);

  buf_state_t state, state_nxt;
  alu_entry_t head, tail;
  alu_entry_t new_entry;
  logic [3:0] new_flags;
  logic       load_head;
  logic       load_tail;
  logic       head_from_tail;

  // Flags are computed once, at push, and travel with the entry so they can
  // never be paired with a different result word.
  alu_flag_gen #(
    .WIDTH (WIDTH)
  ) u_flag_gen (
    .data  (in_data),
    .carry (in_carry),
    .ovf   (in_ovf),
    .flags (new_flags)
  );

  assign new_entry.data  = in_data;
  assign new_entry.tag   = in_tag;
  assign new_entry.flags = new_flags;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake outputs are set only from the current state, so there is no
  // combinational path from either in_valid or out_ready to an output.
  // Loads into the buffer are only ever enabled by a push, so an X on
  // in_data while in_valid=0 never reaches the registers.
  always_comb begin
    state_nxt      = state;
    load_head      = 1'b0;
    load_tail      = 1'b0;
    head_from_tail = 1'b0;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    case (state)
      EMPTY: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = ONE;
          load_head = 1'b1;
        end
      end
      ONE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
        if (in_valid && out_ready) begin
          // Head leaves and the new result replaces it in the same edge.
          load_head = 1'b1;
        end else if (in_valid) begin
          state_nxt = TWO;
          load_tail = 1'b1;
        end else if (out_ready) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt      = ONE;
          load_head      = 1'b1;
          head_from_tail = 1'b1;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  // A popped head is not cleared; out_valid=0 marks it stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= ZERO_ENTRY;
      tail <= ZERO_ENTRY;
    end else begin
      if (load_head) begin
        head <= head_from_tail ? tail : new_entry;
      end
      if (load_tail) begin
        tail <= new_entry;
      end
    end
  end

  assign out_data  = head.data;
  assign out_tag   = head.tag;
  assign out_flags = head.flags;

`ifdef ALU_RESULT_CNT_EN
  // Held at zero throughout reset, so a pop on the release edge is not seen.
  logic pop;
  assign pop = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_count <= '0;
    end else if (pop) begin
      result_count <= result_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage.
// Inputs change 1 time unit after the rising edge; outputs are checked in the
// same window, i.e. they show the state latched by the previous edge.
module tb_alu_result_stage;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] in_tag;
  logic       in_carry;
  logic       in_ovf;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] out_tag;
  logic [3:0] out_flags;
`ifdef ALU_RESULT_CNT_EN
  logic [7:0] result_count;
`endif

  int tests_run;
  int tests_failed;

  alu_result_stage #(
    .WIDTH (4),
    .TAG_W (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .in_carry  (in_carry),
    .in_ovf    (in_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_flags (out_flags)
`ifdef ALU_RESULT_CNT_EN
    ,
    .result_count (result_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic [1:0] t,
                       input logic c, input logic o);
    in_valid = v;
    in_data  = d;
    in_tag   = t;
    in_carry = c;
    in_ovf   = o;
  endtask

  // Streaming vectors: data, tag, expected flags.
  logic [3:0] s_data  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [1:0] s_tag   [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [3:0] s_flags [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000};

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    out_ready    = 1'b0;
    drive(1'b0, 4'hx, 2'b00, 1'b0, 1'b0);
    cyc();
    cyc();
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_out_data",  out_data,  4'b0000);
    check("rst_out_flags", out_flags, 4'b0100);
    cyc();

    // Single transfer: 1000 / tag 11 / carry -> flags N,C
    out_ready = 1'b1;
    drive(1'b1, 4'b1000, 2'b11, 1'b1, 1'b0);
    cyc();
    drive(1'b0, 4'hx, 2'b00, 1'b0, 1'b0);
    check("single_valid", out_valid, 1'b1);
    check("single_data",  out_data,  4'b1000);
    check("single_tag",   out_tag,   2'b11);
    check("single_flags", out_flags, 4'b1010);
    cyc();
    check("single_drained", out_valid, 1'b0);

    // Asynchronous reset mid-cycle while an entry is held
    out_ready = 1'b0;
    drive(1'b1, 4'b0110, 2'b10, 1'b1, 1'b1);
    cyc();
    drive(1'b0, 4'hx, 2'b00, 1'b0, 1'b0);
    check("pre_rst_valid", out_valid, 1'b1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_in_ready",  in_ready,  1'b1);
    check("async_rst_flags",     out_flags, 4'b0100);
    check("async_rst_data",      out_data,  4'b0000);
    check("async_rst_tag",       out_tag,   2'b00);
    cyc();
    rst = 1'b0;
    cyc();
    check("post_rst_empty", out_valid, 1'b0);

    // Back-pressure: fill both entries, third push must be refused
    out_ready = 1'b0;
    drive(1'b1, 4'b0001, 2'b00, 1'b0, 1'b0);
    cyc();
    check("bp_one_in_ready", in_ready, 1'b1);
    drive(1'b1, 4'b0010, 2'b01, 1'b1, 1'b0);
    cyc();
    check("bp_two_in_ready",  in_ready,  1'b0);
    check("bp_two_out_valid", out_valid, 1'b1);
    check("bp_two_head",      out_data,  4'b0001);
    drive(1'b1, 4'b0100, 2'b10, 1'b0, 1'b0);
    cyc();
    check("bp_hold_data",     out_data,  4'b0001);
    check("bp_hold_tag",      out_tag,   2'b00);
    check("bp_hold_in_ready", in_ready,  1'b0);
    drive(1'b0, 4'hx, 2'b00, 1'b0, 1'b0);
    out_ready = 1'b1;
    cyc();
    check("bp_drain2_valid", out_valid, 1'b1);
    check("bp_drain2_data",  out_data,  4'b0010);
    check("bp_drain2_tag",   out_tag,   2'b01);
    check("bp_drain2_flags", out_flags, 4'b0010);
    check("bp_drain2_ready", in_ready,  1'b1);
    cyc();
    check("bp_no_third", out_valid, 1'b0);

    // Streaming with out_ready high: no bubbles, one-cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, s_data[i], s_tag[i], 1'b0, 1'b0);
      cyc();
      check($sformatf("stream%0d_valid", i), out_valid, 1'b1);
      check($sformatf("stream%0d_ready", i), in_ready,  1'b1);
      check($sformatf("stream%0d_data", i),  out_data,  s_data[i]);
      check($sformatf("stream%0d_tag", i),   out_tag,   s_tag[i]);
      check($sformatf("stream%0d_flags", i), out_flags, s_flags[i]);
    end
    drive(1'b0, 4'hx, 2'b00, 1'b0, 1'b0);
    cyc();
    check("stream_drained", out_valid, 1'b0);

    // Zero result with overflow -> Z and V
    drive(1'b1, 4'b0000, 2'b01, 1'b0, 1'b1);
    cyc();
    drive(1'b0, 4'hx, 2'b00, 1'b0, 1'b0);
    check("zero_valid", out_valid, 1'b1);
    check("zero_data",  out_data,  4'b0000);
    check("zero_flags", out_flags, 4'b0101);
    cyc();

`ifdef ALU_RESULT_CNT_EN
    // Pop counter: 257 pops wrap to 1, then reset clears it
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("cnt_reset", result_count, 8'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      drive(1'b1, i[3:0], 2'b00, 1'b0, 1'b0);
      cyc();
    end
    drive(1'b0, 4'hx, 2'b00, 1'b0, 1'b0);
    cyc();
    check("cnt_257_pops", result_count, 8'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'b0011, 2'b00, 1'b0, 1'b0);
      cyc();
    end
    drive(1'b0, 4'hx, 2'b00, 1'b0, 1'b0);
    cyc();
    check("cnt_five", result_count, 8'd5);
    #3 rst = 1'b1;
    #1;
    check("cnt_async_rst", result_count, 8'd0);
    cyc();
    rst = 1'b0;
    cyc();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
